// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared state, tag and width definitions for pixel_frame_sequencer
package frame_seq_pkg;
  localparam int COORD_W = 12;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_DRAIN, S_VBLANK} state_t;
  typedef struct packed {
    logic               valid;
    logic               sof;
    logic               eol;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
  } tag_t;
endpackage

// File: rtl/pixel_frame_sequencer_if.sv
// pixel_frame_sequencer_if: source handshake, halftone coordinates and CFA-aligned tag stream
interface pixel_frame_sequencer_if;
  import frame_seq_pkg::*;
  logic               src_valid;
  logic               src_ready;
  logic [COORD_W-1:0] pix_col;
  logic [COORD_W-1:0] pix_row;
  logic               out_valid;
  logic               out_sof;
  logic               out_eol;
  logic [COORD_W-1:0] out_col;
  logic [COORD_W-1:0] out_row;
  modport master (input src_valid, output src_ready, pix_col, pix_row, out_valid, out_sof, out_eol, out_col, out_row);
  modport slave (output src_valid, input src_ready, pix_col, pix_row, out_valid, out_sof, out_eol, out_col, out_row);
endinterface

// File: rtl/tag_delay_line.sv
// tag_delay_line: DEPTH-stage shift register aligning sideband tags with the datapath output
module tag_delay_line
  import frame_seq_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);
  tag_t r_sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '{default: '0};
    end else begin
      r_sr[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_tag = r_sr[DEPTH-1];
endmodule

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: frame timing FSM, source pacing and delayed tag stream.
// FRAME_AUTO_RESTART_EN: restart the next frame at end of VBLANK unless i_stop is high.
module pixel_frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int H_ACTIVE = 1448,
  parameter int V_ACTIVE = 1072,
  parameter int H_BLANK  = 32,
  parameter int V_BLANK  = 8,
  parameter int PIPE_LAT = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  pixel_frame_sequencer_if.master bus,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_underflow
);
  localparam logic [COORD_W-1:0] L_HLAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] L_VLAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   L_HB    = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]   L_PL    = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0]   L_VB    = CNT_W'(V_BLANK - 1);
  state_t             r_state, w_state_nx;
  logic [COORD_W-1:0] r_col, r_row, w_col_nx, w_row_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_unf, w_unf_nx;
  logic               w_active, w_restart;
  tag_t               w_tag, w_tag_dly;
  assign w_active = r_state == S_ACTIVE;
`ifdef FRAME_AUTO_RESTART_EN
  assign w_restart = !i_stop;
`else
  logic w_unused_stop;
  assign w_unused_stop = i_stop;
  assign w_restart = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_row   <= w_row_nx;
      r_cnt   <= w_cnt_nx;
      r_unf   <= w_unf_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_unf_nx   = r_unf | (w_active & ~bus.src_valid);
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nx = S_ACTIVE;
        w_col_nx   = '0;
        w_row_nx   = '0;
        w_unf_nx   = 1'b0;
      end
      S_ACTIVE: begin
        w_cnt_nx = '0;
        if (r_col == L_HLAST) w_state_nx = r_row < L_VLAST ? S_HBLANK : S_DRAIN;
        else w_col_nx = r_col + COORD_W'(1);
      end
      S_HBLANK: if (r_cnt == L_HB) begin
        w_state_nx = S_ACTIVE;
        w_col_nx   = '0;
        w_row_nx   = r_row + COORD_W'(1);
      end
      S_DRAIN: if (r_cnt == L_PL) begin
        w_state_nx = S_VBLANK;
        w_cnt_nx   = '0;
      end
      S_VBLANK: if (r_cnt == L_VB) begin
        w_state_nx = w_restart ? S_ACTIVE : S_IDLE;
        w_col_nx   = w_restart ? '0 : r_col;
        w_row_nx   = w_restart ? '0 : r_row;
        w_unf_nx   = w_restart ? 1'b0 : r_unf;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
  // blanking cycles push all-zero tags so downstream sees clean invalid slots
  assign w_tag = w_active ? {bus.src_valid, r_col == '0 && r_row == '0, r_col == L_HLAST, r_col, r_row} : '0;
  tag_delay_line #(.DEPTH(PIPE_LAT)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag),
    .o_tag (w_tag_dly)
  );
  assign bus.src_ready = w_active;
  assign bus.pix_col   = r_col;
  assign bus.pix_row   = r_row;
  assign bus.out_valid = w_tag_dly.valid;
  assign bus.out_sof   = w_tag_dly.sof;
  assign bus.out_eol   = w_tag_dly.eol;
  assign bus.out_col   = w_tag_dly.col;
  assign bus.out_row   = w_tag_dly.row;
  assign o_busy        = r_state != S_IDLE;
  assign o_frame_done  = r_state == S_VBLANK && r_cnt == '0;
  assign o_underflow   = r_unf;
endmodule
